// File: rtl/div_sequencer.sv
// 32-iteration restoring divider sequencer for RV32M DIV/DIVU/REM/REMU.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and overflow skip the iterations.
module div_sequencer (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        START,
   input  logic [1:0]  OP,
   input  logic [31:0] DIVIDEND,
   input  logic [31:0] DIVISOR,
   input  logic        FLUSH,
   output logic        BUSY,
   output logic        DONE,
   output logic [31:0] RESULT
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t      state, state_next;
   logic [5:0]  count;
   logic [63:0] acc, acc_step, shifted;
   logic [32:0] trial;
   logic [31:0] dvsr, orig_a, a_abs, b_abs, quo_fix, rem_fix, final_result;
   logic [1:0]  op_q;
   logic        q_neg, r_neg, dz, ovf;
   logic        is_signed, accept, start_dz, start_ovf, early_out;

   assign is_signed = ~OP[0];
   assign accept    = START & ~FLUSH;
   assign start_dz  = (DIVISOR == 32'd0);
   assign start_ovf = is_signed && (DIVIDEND == 32'h8000_0000) && (DIVISOR == 32'hFFFF_FFFF);
   assign a_abs     = (is_signed && DIVIDEND[31]) ? (32'd0 - DIVIDEND) : DIVIDEND;
   assign b_abs     = (is_signed && DIVISOR[31])  ? (32'd0 - DIVISOR)  : DIVISOR;

`ifdef DIV_EARLY_OUT_EN
   assign early_out = start_dz | start_ovf;
`else
   assign early_out = 1'b0;
`endif

   // State register only; BUSY decodes it, so there is no path from START to the stall.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= IDLE;
      else          state <= state_next;
   end

   // NOTE: state_next gets a default before the case so no latch is inferred.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept) state_next = early_out ? FINISH : RUN;
         RUN:     if (count == 6'd1) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (FLUSH) state_next = IDLE;
   end

   // NOTE: combinational logic uses blocking '=', clocked logic uses non-blocking '<='.
   always_comb begin
      shifted  = {acc[62:0], 1'b0};
      trial    = {1'b0, shifted[63:32]} - {1'b0, dvsr};
      acc_step = shifted;
      if (!trial[32]) acc_step = {trial[31:0], shifted[31:1], 1'b1};
   end

   always_comb begin
      quo_fix = q_neg ? (32'd0 - acc[31:0])  : acc[31:0];
      rem_fix = r_neg ? (32'd0 - acc[63:32]) : acc[63:32];
      if (!op_q[1]) final_result = dz ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : quo_fix);
      else          final_result = dz ? orig_a        : (ovf ? 32'd0        : rem_fix);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         count  <= 6'd0;
         acc    <= 64'd0;
         dvsr   <= 32'd0;
         orig_a <= 32'd0;
         op_q   <= 2'b00;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         dz     <= 1'b0;
         ovf    <= 1'b0;
         DONE   <= 1'b0;
         RESULT <= 32'd0;
      end else begin
         DONE <= 1'b0;
         unique case (state)
            IDLE: if (accept) begin
               acc    <= {32'd0, a_abs};
               dvsr   <= b_abs;
               orig_a <= DIVIDEND;
               op_q   <= OP;
               q_neg  <= is_signed & ~OP[1] & (DIVIDEND[31] ^ DIVISOR[31]);
               r_neg  <= is_signed &  OP[1] &  DIVIDEND[31];
               dz     <= start_dz;
               ovf    <= start_ovf;
               count  <= 6'd32;
            end
            RUN: if (!FLUSH) begin
               acc   <= acc_step;
               count <= count - 6'd1;
            end
            FINISH: if (!FLUSH) begin
               RESULT <= final_result;
               DONE   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: arithmetic reference model plus directed literal checks.
module tb_div_sequencer;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        START = 1'b0;
   logic [1:0]  OP = 2'b00;
   logic [31:0] DIVIDEND = 32'd0;
   logic [31:0] DIVISOR = 32'd0;
   logic        FLUSH = 1'b0;
   logic        BUSY, DONE;
   logic [31:0] RESULT;

`ifdef DIV_EARLY_OUT_EN
   localparam int LAT_EXC = 1;
`else
   localparam int LAT_EXC = 33;
`endif

   int n_cmp = 0;
   int n_fail = 0;
   logic cmp_en = 1'b0;

   // reference model state
   logic        m_busy, m_done;
   logic [31:0] m_result, m_pend;
   int          m_left;

   div_sequencer dut (
      .CLK(CLK), .RESET_N(RESET_N), .START(START), .OP(OP),
      .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR), .FLUSH(FLUSH),
      .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'd0 : 32'h8000_0000;
      case (op)
         2'b00:   return 32'(sa / sb);
         2'b01:   return a / b;
         2'b10:   return 32'(sa % sb);
         default: return a % b;
      endcase
   endfunction

   function automatic int model_latency(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
      if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return LAT_EXC;
      return 33;
   endfunction

   // Transaction-level model: countdown to a DONE pulse carrying the arithmetic result.
   always @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_result <= 32'd0; m_pend <= 32'd0; m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (FLUSH) m_busy <= 1'b0;
            else if (m_left == 1) begin
               m_busy <= 1'b0; m_done <= 1'b1; m_result <= m_pend;
            end else m_left <= m_left - 1;
         end else if (START && !FLUSH) begin
            m_busy <= 1'b1;
            m_left <= model_latency(OP, DIVIDEND, DIVISOR);
            m_pend <= model_result(OP, DIVIDEND, DIVISOR);
         end
      end
   end

   always @(negedge CLK) begin
      if (cmp_en && RESET_N === 1'b1) begin
         check("cyc_busy",   {31'd0, BUSY}, {31'd0, m_busy});
         check("cyc_done",   {31'd0, DONE}, {31'd0, m_done});
         check("cyc_result", RESULT, m_result);
      end
   end

   // Issues one op from the current (non-edge) time and waits for DONE; poke>0 pulses a
   // stray START on that busy cycle, which must be ignored.
   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input int poke);
      int lat, busy_n;
      bit seen;
      START = 1'b1; OP = op; DIVIDEND = a; DIVISOR = b;
      @(posedge CLK); #1;
      START = 1'b0;
      lat = 0; seen = 0;
      busy_n = BUSY ? 1 : 0;
      while (!seen && lat < 60) begin
         if (poke > 0 && lat == poke) begin
            START = 1'b1; OP = 2'b01; DIVIDEND = 32'd9; DIVISOR = 32'd3;
         end else START = 1'b0;
         @(posedge CLK); #1;
         lat++;
         if (DONE) seen = 1;
         else if (BUSY) busy_n++;
      end
      START = 1'b0;
      check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat));
      check({name, "_result"}, RESULT, exp);
      check({name, "_busy_in_done"}, {31'd0, BUSY}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      #12;
      check("rst_busy",   {31'd0, BUSY}, 32'd0);
      check("rst_done",   {31'd0, DONE}, 32'd0);
      check("rst_result", RESULT, 32'd0);
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      cmp_en = 1'b1;
      @(posedge CLK); #1;

      run_op("div_100_7", 2'b00, 32'd100, 32'd7, 32'h0000_000E, 33, 0);
      // back-to-back chain: each START lands in the previous DONE cycle
      run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
      run_op("remu_m7_2",  2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 33, 0);
      run_op("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 0);
      run_op("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 0);
      run_op("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 33, 0);
      run_op("div_7_m7",   2'b00, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 33, 0);
      run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 0);
      run_op("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0);

      run_op("divu_5_0",   2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_EXC, 0);
      run_op("rem_x_0",    2'b10, 32'h8000_0005, 32'd0, 32'h8000_0005, LAT_EXC, 0);
      run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_EXC, 0);
      run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_EXC, 0);
      run_op("div_0_0",    2'b00, 32'd0, 32'd0, 32'hFFFF_FFFF, LAT_EXC, 0);
      run_op("remu_7_0",   2'b11, 32'd7, 32'd0, 32'h0000_0007, LAT_EXC, 0);
      repeat (2) @(posedge CLK);
      #1;

      // FLUSH during cycle 10 of a DIV
      START = 1'b1; OP = 2'b00; DIVIDEND = 32'd100; DIVISOR = 32'd7;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (9) @(posedge CLK);
      #1 FLUSH = 1'b1;
      @(posedge CLK); #1;
      FLUSH = 1'b0;
      check("flush_busy",   {31'd0, BUSY}, 32'd0);
      check("flush_done",   {31'd0, DONE}, 32'd0);
      check("flush_result", RESULT, 32'h0000_0007);
      run_op("after_flush", 2'b00, 32'd1000, 32'd10, 32'h0000_0064, 33, 5);

      // FLUSH together with START in IDLE drops the request
      @(posedge CLK); #1;
      START = 1'b1; FLUSH = 1'b1; OP = 2'b01; DIVIDEND = 32'd50; DIVISOR = 32'd5;
      @(posedge CLK); #1;
      START = 1'b0; FLUSH = 1'b0;
      check("flush_start_busy", {31'd0, BUSY}, 32'd0);
      repeat (3) @(posedge CLK);
      #1 check("flush_start_result", RESULT, 32'h0000_0064);

      // asynchronous reset in the middle of RUN
      START = 1'b1; OP = 2'b00; DIVIDEND = 32'd77; DIVISOR = 32'd3;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (5) @(posedge CLK);
      #2 RESET_N = 1'b0;
      #1;
      check("arst_busy",   {31'd0, BUSY}, 32'd0);
      check("arst_done",   {31'd0, DONE}, 32'd0);
      check("arst_result", RESULT, 32'd0);
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      dones = 0;
      repeat (40) begin
         @(posedge CLK); #1;
         if (DONE) dones++;
      end
      check("arst_no_done", 32'(dones), 32'd0);
      check("arst_idle_busy", {31'd0, BUSY}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
